// File: rtl/dc_bsp_pkg.sv
// Board-support package shared by the ASP blocks.
// Holds the interrupt line map of the board, the CSR word offsets and
// identification constant of the ASP interrupt controller, and the
// controller's request FSM state type.
package dc_bsp_pkg;

    // Interrupt source lines wired into the ASP interrupt controller.
    localparam int BSP_NUM_INTERRUPT_LINES = 4;
    localparam int BSP_DMA_0_IRQ_BIT       = 0;
    localparam int BSP_KERNEL_IRQ_BIT      = 1;
    localparam int BSP_DMA_1_IRQ_BIT       = 2;

    // Width of the vector index handed to the host interrupt interface.
    localparam int ASP_IRQ_VEC_W = 2;

    // CSR word offsets (byte offset >> 3).
    localparam logic [2:0] ASP_IRQ_CSR_STATUS = 3'd0;
    localparam logic [2:0] ASP_IRQ_CSR_ENABLE = 3'd1;
    localparam logic [2:0] ASP_IRQ_CSR_CLEAR  = 3'd2;
    localparam logic [2:0] ASP_IRQ_CSR_COUNT  = 3'd3;
    localparam logic [2:0] ASP_IRQ_CSR_ID     = 3'd4;

    // Constant returned by the ID register.
    localparam logic [63:0] ASP_IRQ_ID = 64'h0000_4952_5143_0001;

    // Request FSM: IDLE looks for an eligible line, REQ holds a request
    // until the host acknowledges it.
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } irq_fsm_e;

endpackage

// File: rtl/asp_irq_rr_arb.sv
// Round-robin arbiter for the ASP interrupt controller.
// Purely combinational: picks the first requesting line strictly after
// the pointer, wrapping around, so the last winner has lowest priority.
//
// Ports:
//   req   in  N      request vector (one bit per line)
//   ptr   in  IDX_W  index of the most recently granted line
//   grant out N      one-hot grant (all zero when nothing requests)
//   idx   out IDX_W  encoded index of the granted line
module asp_irq_rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    int          pos;
    logic [N-1:0] rq;

    always_comb begin
        grant = '0;
        idx   = '0;
        pos   = 0;
        rq    = '0;
        // Scan from the farthest candidate back toward ptr+1; the last hit
        // written is therefore the nearest eligible line after the pointer.
        for (int k = N; k >= 1; k--) begin
            pos = (int'(ptr) + k) % N;
            rq  = req >> pos;
            if (rq[0]) begin
                grant = N'(1) << pos;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/asp_irq_ctrl.sv
// ASP interrupt controller.
// Edge-detects level interrupt sources into a pending register, masks
// them with a software enable, and issues one host vector request at a
// time (round-robin, valid/ack handshake). A 64-bit AVMM CSR slave
// exposes status, enable, clear and per-line delivery counters.
//
// Ports:
//   clk                in   sole clock
//   reset              in   asynchronous active-high reset
//   irq_in             in   NUM_LINES level sources (sync to clk)
//   irq_valid          out  vector request to host
//   irq_vector         out  line index of current request
//   irq_ack            in   host accepted the request
//   csr_address        in   64-bit word address
//   csr_read/write     in   AVMM commands
//   csr_writedata      in   write data
//   csr_readdata       out  read data (held until next read)
//   csr_readdatavalid  out  read response strobe, 1 cycle after read
//   csr_waitrequest    out  always 0
module asp_irq_ctrl
    import dc_bsp_pkg::*;
#(
    parameter int NUM_LINES = BSP_NUM_INTERRUPT_LINES,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_LINES-1:0]     irq_in,
    output logic                     irq_valid,
    output logic [ASP_IRQ_VEC_W-1:0] irq_vector,
    input  logic                     irq_ack,
    input  logic [2:0]               csr_address,
    input  logic                     csr_read,
    input  logic                     csr_write,
    input  logic [63:0]              csr_writedata,
    output logic [63:0]              csr_readdata,
    output logic                     csr_readdatavalid,
    output logic                     csr_waitrequest
);

    localparam int VEC_W = ASP_IRQ_VEC_W;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == '1) ? c : c + CNT_WIDTH'(1);
    endfunction

    logic [NUM_LINES-1:0] irq_in_q, irq_q;
    logic [NUM_LINES-1:0] pending_q, pending_d;
    logic [NUM_LINES-1:0] enable_q, enable_d;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_LINES];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_LINES];
    logic [VEC_W-1:0]     ptr_q, ptr_d;
    logic [VEC_W-1:0]     vector_q, vector_d;
    irq_fsm_e             state_q, state_d;
    logic [63:0]          rdata_q, rdata_d;
    logic                 rvld_q, rvld_d;

    logic [NUM_LINES-1:0] rise, ack_mask, clr_mask, arb_grant;
    logic [VEC_W-1:0]     arb_idx;
    logic                 ack_fire;
    logic [63:0]          status_w, count_w;
    logic                 unused_wdata;

    assign unused_wdata = ^csr_writedata[63:NUM_LINES];

    // Two-deep input register: irq_in_q is the sampled level, irq_q its
    // previous value, so a rise lands in pending two cycles after irq_in.
    assign rise = irq_in_q & ~irq_q;

    asp_irq_rr_arb #(
        .N     (NUM_LINES),
        .IDX_W (VEC_W)
    ) u_arb (
        .req   (pending_q & enable_q),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Request FSM: once a request is issued it is held until acked,
    // regardless of later pending/enable changes.
    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        ptr_d    = ptr_q;
        ack_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|arb_grant) begin
                    vector_d = arb_idx;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    ack_fire = 1'b1;
                    ptr_d    = vector_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_mask = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            ack_mask[i] = ack_fire && (vector_q == VEC_W'(i));
        end
    end

    assign clr_mask = (csr_write && csr_address == ASP_IRQ_CSR_CLEAR)
                      ? csr_writedata[NUM_LINES-1:0] : '0;

    // A new rise wins over both ack clear and software clear.
    always_comb begin
        pending_d = (pending_q & ~ack_mask & ~clr_mask) | rise;
        enable_d  = enable_q;
        if (csr_write && csr_address == ASP_IRQ_CSR_ENABLE) begin
            enable_d = csr_writedata[NUM_LINES-1:0];
        end
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (ack_mask[i]) begin
                cnt_d[i] = sat_inc(cnt_q[i]);
            end
        end
    end

    // CSR read path: registered, one response per read, data held between reads.
    always_comb begin
        status_w                 = '0;
        status_w[NUM_LINES-1:0]  = pending_q;
        status_w[63]             = (state_q == REQ);
        count_w                  = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            count_w[16*i +: 16] = 16'(cnt_q[i]);
        end
        rdata_d = rdata_q;
        rvld_d  = csr_read;
        if (csr_read) begin
            unique case (csr_address)
                ASP_IRQ_CSR_STATUS: rdata_d = status_w;
                ASP_IRQ_CSR_ENABLE: rdata_d = 64'(enable_q);
                ASP_IRQ_CSR_COUNT:  rdata_d = count_w;
                ASP_IRQ_CSR_ID:     rdata_d = ASP_IRQ_ID;
                default:            rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_in_q  <= '0;
            irq_q     <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            cnt_q     <= '{default: '0};
            ptr_q     <= VEC_W'(NUM_LINES - 1);
            vector_q  <= '0;
            state_q   <= IDLE;
            rdata_q   <= '0;
            rvld_q    <= 1'b0;
        end else begin
            irq_in_q  <= irq_in;
            irq_q     <= irq_in_q;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            vector_q  <= vector_d;
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            rvld_q    <= rvld_d;
        end
    end

    assign irq_valid         = (state_q == REQ);
    assign irq_vector        = vector_q;
    assign csr_readdata      = rdata_q;
    assign csr_readdatavalid = rvld_q;
    assign csr_waitrequest   = 1'b0;

endmodule

// File: tb/tb_asp_irq_ctrl.sv
module tb_asp_irq_ctrl;

    localparam int NL    = 4;
    // Narrow counters so saturation is reachable in a short run.
    localparam int CW    = 8;
    localparam int LMASK = (1 << NL) - 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_in;
    logic        irq_valid;
    logic [1:0]  irq_vector;
    logic        irq_ack;
    logic [2:0]  csr_address;
    logic        csr_read;
    logic        csr_write;
    logic [63:0] csr_writedata;
    logic [63:0] csr_readdata;
    logic        csr_readdatavalid;
    logic        csr_waitrequest;

    always #5 clk = ~clk;

    asp_irq_ctrl #(
        .NUM_LINES (NL),
        .CNT_WIDTH (CW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .irq_in            (irq_in),
        .irq_valid         (irq_valid),
        .irq_vector        (irq_vector),
        .irq_ack           (irq_ack),
        .csr_address       (csr_address),
        .csr_read          (csr_read),
        .csr_write         (csr_write),
        .csr_writedata     (csr_writedata),
        .csr_readdata      (csr_readdata),
        .csr_readdatavalid (csr_readdatavalid),
        .csr_waitrequest   (csr_waitrequest)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (values after the most recent clock edge).
    int          m_in1, m_in2, m_pend, m_en, m_ptr, m_vec;
    bit          m_valid, m_rvld;
    int          m_cnt [NL];
    logic [63:0] m_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in1 = 0; m_in2 = 0; m_pend = 0; m_en = 0;
        m_ptr = NL - 1; m_vec = 0; m_valid = 0; m_rvld = 0; m_rdata = '0;
        for (int i = 0; i < NL; i++) m_cnt[i] = 0;
    endtask

    function automatic logic [63:0] m_read(input int a);
        logic [63:0] v;
        v = '0;
        case (a)
            0: begin
                v = 64'(m_pend);
                if (m_valid) v[63] = 1'b1;
            end
            1: v = 64'(m_en);
            3: for (int i = 0; i < NL; i++) v = v | (64'(m_cnt[i]) << (16 * i));
            4: v = 64'h0000_4952_5143_0001;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_clock();
        int rise, ackm, clr, elig, nptr, nvec, nen, c;
        bit nvalid;
        int ncnt [NL];
        rise   = m_in1 & ~m_in2 & LMASK;
        ackm   = 0;
        clr    = 0;
        nvalid = m_valid;
        nvec   = m_vec;
        nptr   = m_ptr;
        nen    = m_en;
        ncnt   = m_cnt;
        if (csr_write && csr_address == 3'd2) clr = int'(csr_writedata[NL-1:0]);
        if (csr_write && csr_address == 3'd1) nen = int'(csr_writedata[NL-1:0]);
        if (!m_valid) begin
            elig = m_pend & m_en;
            for (int k = 1; k <= NL; k++) begin
                c = (m_ptr + k) % NL;
                if (((elig >> c) & 1) != 0) begin
                    nvalid = 1'b1;
                    nvec   = c;
                    break;
                end
            end
        end else if (irq_ack) begin
            ackm   = 1 << m_vec;
            nvalid = 1'b0;
            nptr   = m_vec;
            if (ncnt[m_vec] < CMAX) ncnt[m_vec] = ncnt[m_vec] + 1;
        end
        if (csr_read) m_rdata = m_read(int'(csr_address));
        m_rvld  = csr_read;
        m_pend  = ((m_pend & ~ackm & ~clr) | rise) & LMASK;
        m_en    = nen;
        m_valid = nvalid;
        m_vec   = nvec;
        m_ptr   = nptr;
        m_cnt   = ncnt;
        m_in2   = m_in1;
        m_in1   = int'(irq_in);
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check("valid", 64'(irq_valid), 64'(m_valid));
        check("vector", 64'(irq_vector), 64'(m_vec));
        check("rvld", 64'(csr_readdatavalid), 64'(m_rvld));
        check("rdata", csr_readdata, m_rdata);
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [63:0] d);
        csr_write = 1'b1; csr_address = a; csr_writedata = d;
        step();
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [63:0] d);
        csr_read = 1'b1; csr_address = a;
        step();
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (irq_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) check("valid_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    // Called at a negative edge; resets DUT and model together.
    task automatic do_reset();
        reset = 1'b1;
        irq_ack = 1'b0; csr_read = 1'b0; csr_write = 1'b0; irq_in = '0;
        model_reset();
        #1;
        check("rst_async_valid", 64'(irq_valid), 64'(0));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        bit          ok;
        int          r;

        reset = 1'b1; irq_in = '0; irq_ack = 1'b0;
        csr_address = '0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_irq_valid", 64'(irq_valid), 64'(0));
        check("rst_irq_vector", 64'(irq_vector), 64'(0));
        check("rst_readdata", csr_readdata, 64'(0));
        check("rst_rdvalid", 64'(csr_readdatavalid), 64'(0));
        check("waitrequest", 64'(csr_waitrequest), 64'(0));
        reset = 1'b0;

        // Single line: latency and delivery count.
        csr_wr(3'd1, 64'h7);
        irq_in = 4'b0010;
        step();
        irq_in = 4'b0000;
        step();
        check("t1_no_req_yet", 64'(irq_valid), 64'(0));
        step();
        check("t1_valid", 64'(irq_valid), 64'(1));
        check("t1_vector", 64'(irq_vector), 64'(1));
        do_ack();
        csr_rd(3'd0, d);
        check("t1_status", d, 64'(0));
        csr_rd(3'd3, d);
        check("t1_count1", 64'(d[31:16]), 64'(1));

        // Held level with line masked, then enable.
        csr_wr(3'd1, 64'h0);
        irq_in = 4'b0001;
        repeat (4) step();
        csr_rd(3'd0, d);
        check("t2_status", d, 64'h1);
        check("t2_no_req", 64'(irq_valid), 64'(0));
        csr_wr(3'd1, 64'h1);
        step();
        check("t2_valid", 64'(irq_valid), 64'(1));
        check("t2_vector", 64'(irq_vector), 64'(0));
        do_ack();
        repeat (3) step();
        check("t2_no_retrigger", 64'(irq_valid), 64'(0));
        irq_in = 4'b0000;
        step();

        // Fairness from a fresh pointer, two rounds.
        do_reset();
        csr_wr(3'd1, 64'h7);
        for (int rnd = 0; rnd < 2; rnd++) begin
            irq_in = 4'b0111;
            step();
            irq_in = 4'b0000;
            for (int k = 0; k < 3; k++) begin
                wait_valid(ok);
                check("fair_vector", 64'(irq_vector), 64'(k));
                step();
                do_ack();
            end
        end

        // Rise, ack and CLEAR all on line 2 in the same cycle.
        csr_wr(3'd1, 64'h4);
        irq_in = 4'b0100;
        step();
        irq_in = 4'b0000;
        wait_valid(ok);
        check("col_vector", 64'(irq_vector), 64'(2));
        irq_in = 4'b0100;
        step();
        irq_ack = 1'b1; csr_write = 1'b1; csr_address = 3'd2; csr_writedata = 64'h4;
        irq_in = 4'b0000;
        step();
        irq_ack = 1'b0; csr_write = 1'b0;
        check("col_valid_drop", 64'(irq_valid), 64'(0));
        csr_rd(3'd0, d);
        check("col_status", d, 64'h4);
        check("col_second_req", 64'(irq_valid), 64'(1));
        check("col_second_vec", 64'(irq_vector), 64'(2));
        do_ack();

        // Reset while a request is outstanding.
        irq_in = 4'b0100;
        step();
        irq_in = 4'b0000;
        wait_valid(ok);
        do_reset();
        for (int a = 0; a < 8; a++) begin
            csr_rd(3'(a), d);
            check("post_rst_csr", d, (a == 4) ? 64'h0000_4952_5143_0001 : 64'(0));
        end

        // Counter saturation on line 0.
        csr_wr(3'd1, 64'h1);
        for (int n = 0; n < CMAX + 4; n++) begin
            irq_in = 4'b0001;
            step();
            irq_in = 4'b0000;
            wait_valid(ok);
            if (!ok) break;
            do_ack();
        end
        csr_rd(3'd3, d);
        check("sat_count0", 64'(d[15:0]), 64'(CMAX));
        check("sat_others", 64'(d[63:16]), 64'(0));

        // Randomized traffic against the model.
        do_reset();
        csr_wr(3'd1, 64'($urandom_range(0, 15)));
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 3) == 0) irq_in = 4'($urandom);
            irq_ack = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            csr_read = 1'b0; csr_write = 1'b0;
            csr_address = 3'($urandom);
            if (r < 4) begin
                csr_read = 1'b1;
            end else if (r < 6) begin
                csr_write = 1'b1;
                csr_writedata = {32'($urandom), 32'($urandom)};
            end
            step();
        end
        csr_read = 1'b0; csr_write = 1'b0; irq_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
